// File: rtl/spart_pkg.sv
// rtl/spart_pkg.sv - shared constants and state type for the SPART bus-master driver
package spart_pkg;
  localparam logic [1:0] ADDR_BUF  = 2'b00;
  localparam logic [1:0] ADDR_STAT = 2'b01;
  localparam logic [1:0] ADDR_DBL  = 2'b10;
  localparam logic [1:0] ADDR_DBH  = 2'b11;

  localparam int STAT_RDA = 0;
  localparam int STAT_TBR = 1;

  localparam logic [15:0] DIV_4800_DEF  = 16'h028C;
  localparam logic [15:0] DIV_9600_DEF  = 16'h0145;
  localparam logic [15:0] DIV_19200_DEF = 16'h00A3;
  localparam logic [15:0] DIV_38400_DEF = 16'h0052;

  typedef enum logic [2:0] {
    PROG_LO,
    PROG_HI,
    WAIT_RDA,
    RD_RX,
    WAIT_TBR,
    WR_TX
  } drv_state_t;
endpackage

// File: rtl/spart_driver_sync2.sv
// rtl/spart_driver_sync2.sv - two-flop synchronizer, cleared by async reset
module sync2 #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] d_i,
  output logic [W-1:0] q_o
);
  logic [W-1:0] meta_q;
  logic [W-1:0] sync_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= '0;
      sync_q <= '0;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;
endmodule

// File: rtl/spart_driver.sv
// rtl/spart_driver.sv - programs the SPART baud divisor, then echoes every received byte
module spart_driver
  import spart_pkg::*;
#(
  parameter logic [15:0] DIV_4800       = DIV_4800_DEF,
  parameter logic [15:0] DIV_9600       = DIV_9600_DEF,
  parameter logic [15:0] DIV_19200      = DIV_19200_DEF,
  parameter logic [15:0] DIV_38400      = DIV_38400_DEF,
  parameter bit          USE_STATUS_REG = 1'b0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [1:0]  br_cfg,
  output logic        iocs,
  output logic        iorw,
  output logic [1:0]  ioaddr,
  inout  wire  [7:0]  databus,
  input  logic        rda,
  input  logic        tbr,
  output logic [7:0]  last_rx,
  output logic [15:0] echo_cnt
);
  drv_state_t  state_q;
  logic [1:0]  sync_cfg;
  logic [1:0]  cfg_q;
  logic [1:0]  warm_q;
  logic        iocs_q;
  logic        iorw_q;
  logic [1:0]  ioaddr_q;
  logic [7:0]  dout_q;
  logic [7:0]  rx_hold_q;
  logic [7:0]  last_rx_q;
  logic [15:0] echo_cnt_q;
  logic [15:0] div_w;
  logic        poll_vis;
  logic        rd_ok;
  logic        wr_ok;

  sync2 #(.W(2)) u_cfg_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d_i   (br_cfg),
    .q_o   (sync_cfg)
  );

  always_comb begin
    div_w = DIV_4800;
    case (cfg_q)
      2'b00: div_w = DIV_4800;
      2'b01: div_w = DIV_9600;
      2'b10: div_w = DIV_19200;
      2'b11: div_w = DIV_38400;
      default: div_w = DIV_4800;
    endcase
  end

  // A status poll is on the bus this cycle; its data is sampled at the closing edge.
  assign poll_vis = iocs_q & iorw_q & (ioaddr_q == ADDR_STAT);
  assign rd_ok    = USE_STATUS_REG ? (poll_vis & (databus[STAT_RDA] === 1'b1)) : (rda === 1'b1);
  assign wr_ok    = USE_STATUS_REG ? (poll_vis & (databus[STAT_TBR] === 1'b1)) : (tbr === 1'b1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= PROG_LO;
      cfg_q      <= 2'b00;
      warm_q     <= 2'd0;
      iocs_q     <= 1'b0;
      iorw_q     <= 1'b1;
      ioaddr_q   <= ADDR_BUF;
      dout_q     <= 8'h00;
      rx_hold_q  <= 8'h00;
      last_rx_q  <= 8'h00;
      echo_cnt_q <= 16'h0000;
    end else begin
      iocs_q   <= 1'b0;
      iorw_q   <= 1'b1;
      ioaddr_q <= ADDR_BUF;
      case (state_q)
        PROG_LO: begin
          // Let the synchronizer fill after reset so the first divisor matches the switches.
          if (warm_q != 2'd3) begin
            warm_q <= warm_q + 2'd1;
            cfg_q  <= sync_cfg;
          end else begin
            iocs_q   <= 1'b1;
            iorw_q   <= 1'b0;
            ioaddr_q <= ADDR_DBL;
            dout_q   <= div_w[7:0];
            state_q  <= PROG_HI;
          end
        end
        PROG_HI: begin
          iocs_q   <= 1'b1;
          iorw_q   <= 1'b0;
          ioaddr_q <= ADDR_DBH;
          dout_q   <= div_w[15:8];
          state_q  <= WAIT_RDA;
        end
        WAIT_RDA: begin
          if (sync_cfg != cfg_q) begin
            cfg_q   <= sync_cfg;
            state_q <= PROG_LO;
          end else if (rd_ok) begin
            iocs_q   <= 1'b1;
            ioaddr_q <= ADDR_BUF;
            state_q  <= RD_RX;
          end else if (USE_STATUS_REG) begin
            iocs_q   <= 1'b1;
            ioaddr_q <= ADDR_STAT;
          end
        end
        RD_RX: begin
          rx_hold_q <= databus;
          last_rx_q <= databus;
          state_q   <= WAIT_TBR;
        end
        WAIT_TBR: begin
          if (wr_ok) begin
            iocs_q   <= 1'b1;
            iorw_q   <= 1'b0;
            ioaddr_q <= ADDR_BUF;
            dout_q   <= rx_hold_q;
            state_q  <= WR_TX;
          end else if (USE_STATUS_REG) begin
            iocs_q   <= 1'b1;
            ioaddr_q <= ADDR_STAT;
          end
        end
        WR_TX: begin
          echo_cnt_q <= echo_cnt_q + 16'd1;
          state_q    <= WAIT_RDA;
        end
        default: state_q <= PROG_LO;
      endcase
    end
  end

  assign databus  = (iocs_q & ~iorw_q) ? dout_q : 8'hzz;
  assign iocs     = iocs_q;
  assign iorw     = iorw_q;
  assign ioaddr   = ioaddr_q;
  assign last_rx  = last_rx_q;
  assign echo_cnt = echo_cnt_q;
endmodule
